// File: rtl/manchester_pkg.sv
// Definitions shared by the Manchester encoder and decoder: FSM states,
// line-code polarity and default sizing.
package manchester_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    // IEEE 802.3 polarity: a rising mid-bit transition encodes a '1'
    localparam logic MC_ONE_RISE = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b0;

    localparam int DEFAULT_OVERSAMPLE = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/manchester_edge_sync.sv
// Brings the asynchronous Manchester line into the clock domain and flags
// its transitions one register behind the synchronizer.
module manchester_edge_sync
    import manchester_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic line_in,
    output logic any_edge,
    output logic rise,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Two-stage synchronizer followed by the edge-reference register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_r <= IDLE_LEVEL;
            s2_r <= IDLE_LEVEL;
            s3_r <= IDLE_LEVEL;
        end else begin
            s1_r <= line_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign any_edge = s2_r ^ s3_r;
    assign rise     = s2_r & ~s3_r;
    assign fall     = ~s2_r & s3_r;

endmodule

// File: rtl/manchester_decoder.sv
// Manchester receive path: recovers bits from mid-bit transitions, re-timing
// on every accepted edge, and emits framed words MSB-first.
module manchester_decoder
    import manchester_pkg::*;
#(
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  line_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int CNT_LO = (3 * OVERSAMPLE) / 4;
    localparam int CNT_HI = (5 * OVERSAMPLE) / 4;
    localparam int CNT_W  = $clog2(CNT_HI + 1);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LO_V    = CNT_W'(CNT_LO);
    localparam logic [CNT_W-1:0] CNT_HI_V    = CNT_W'(CNT_HI);
    localparam logic [CNT_W-1:0] CNT_GUARD_V = CNT_W'(OVERSAMPLE);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_WIDTH);

    logic any_edge_s;
    logic rise_s;
    logic fall_s;

    state_e                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s, cnt_sat_s;
    logic [BIT_W-1:0]      bitcnt_r, bitcnt_s, bitcnt_inc_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s, shifted_s;
    logic [DATA_WIDTH-1:0] data_r, data_s;
    logic                  valid_r, valid_s;
    logic                  err_r, err_s;
    logic                  busy_r, busy_s;
    logic                  bit_s;
    logic                  accept_s;

    manchester_edge_sync u_edge_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .line_in  (line_in),
        .any_edge (any_edge_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

    // cnt is restarted at 1 on an accepted edge so that, at the next sampled
    // edge, it equals the number of clocks between the two transitions.
    assign cnt_sat_s    = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    assign bitcnt_inc_s = bitcnt_r + BIT_W'(1);
    assign bit_s        = fall_s ? ~MC_ONE_RISE : MC_ONE_RISE;
    assign shifted_s    = DATA_WIDTH'({shift_r, bit_s});
    assign accept_s     = any_edge_s && (cnt_r >= CNT_LO_V) && (cnt_r <= CNT_HI_V);

    // Next-state, datapath and strobe decode
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_sat_s;
        bitcnt_s = bitcnt_r;
        shift_s  = shift_r;
        data_s   = data_r;
        valid_s  = 1'b0;
        err_s    = 1'b0;
        if (!ena) begin
            state_s  = ST_IDLE;
            cnt_s    = '0;
            bitcnt_s = '0;
            shift_s  = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        state_s  = ST_DATA;
                        cnt_s    = CNT_ONE;
                        bitcnt_s = '0;
                        shift_s  = '0;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // An in-window edge at the upper limit beats the timeout
                    if (accept_s) begin
                        shift_s  = shifted_s;
                        cnt_s    = CNT_ONE;
                        bitcnt_s = bitcnt_inc_s;
                        if (bitcnt_inc_s == BIT_LAST) begin
                            data_s  = shifted_s;
                            valid_s = 1'b1;
                            state_s = ST_GUARD;
                        end else begin
                            state_s = ST_DATA;
                        end
                    end else if (cnt_r > CNT_HI_V) begin
                        err_s   = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_GUARD: begin
                    if (cnt_r >= CNT_GUARD_V) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_GUARD;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State, counters, shift register and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            bitcnt_r <= '0;
            shift_r  <= '0;
            data_r   <= '0;
            valid_r  <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            bitcnt_r <= bitcnt_s;
            shift_r  <= shift_s;
            data_r   <= data_s;
            valid_r  <= valid_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
        end
    end

    assign data_out   = data_r;
    assign data_valid = valid_r;
    assign frame_err  = err_r;
    assign busy       = busy_r;

endmodule

// File: doc/manchester_decoder.md
# manchester_decoder

Receive-side counterpart to the Manchester encoder in `tt_um_manchester`. It samples an asynchronous Manchester line at `OVERSAMPLE` clocks per bit and recovers each bit from its mid-bit transition, re-timing on every accepted edge. It assembles framed bytes MSB-first and emits them with a one-cycle valid strobe. It sits behind the TinyTapeout top as its receive path; the top maps `line_in` and the outputs onto `ui_in`/`uo_out`/`uio_*` pins.

## Interface
- `OVERSAMPLE`, default 8: clocks per bit period. Must be a multiple of 4, range 8..64.
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `ena`  in  1  design enable. Low forces IDLE and suppresses strobes.
- `line_in`  in  1  asynchronous Manchester line. Idles low.
- `data_out`  out  DATA_WIDTH  last good byte. Holds until the next good frame.
- `data_valid`  out  1  one-cycle pulse; `data_out` is valid in the same cycle.
- `frame_err`  out  1  one-cycle pulse on a missing mid-bit edge.
- `busy`  out  1  high while in DATA or GUARD.

## Operation
- **Line code** (IEEE 802.3): a rising mid-bit edge is 1, a falling mid-bit edge is 0. Bit-boundary edges carry no data.
- **Frame:** start bit '1' (low half, then rising at mid-bit), then `DATA_WIDTH` data bits, MSB first. The line returns low afterwards.
- **Front end:** `line_in` passes through a 2-FF synchronizer into a third register, `s3`. `edge` = `s2 != s3`; `rise` = `s2 & ~s3`.
- **Bit counter:** `cnt` counts clocks since the last accepted mid-bit edge. Width is clog2(5*OVERSAMPLE/4 + 1). It saturates and never wraps.
- **FSM states:** IDLE, DATA, GUARD.
  - **IDLE:**
    - `rise`: clear `cnt` and `bitcnt`, go to DATA. This rise is the start bit's mid-edge.
    - Falling edges are ignored.
  - **DATA:**
    - Edges with `cnt < 3*OVERSAMPLE/4` are boundary edges and are ignored.
    - An edge with `3*OVERSAMPLE/4 <= cnt <= 5*OVERSAMPLE/4` is accepted:
      - shift `rise` into the shift register LSB;
      - clear `cnt`;
      - increment `bitcnt`.
    - When `bitcnt` reaches `DATA_WIDTH`: load `data_out`, pulse `data_valid`, go to GUARD.
    - `cnt` exceeding `5*OVERSAMPLE/4` with no accepted edge: pulse `frame_err`, go to IDLE. `data_out` is unchanged.
  - **GUARD:** ignore all edges for `OVERSAMPLE` clocks from the last accepted edge, then go to IDLE. This absorbs the trailing boundary fall after a final '1'.
- **Simultaneous events:** an accepted edge at `cnt == 5*OVERSAMPLE/4` wins over timeout.
- **`ena` low, any state:** next state IDLE, shift register and counters cleared, no strobes. `data_out` holds.
- **Reset mid-frame:** the partial frame is discarded with no strobe. Next `rise` in IDLE starts a new frame.

## Timing
- **Reset values:**
  - `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `busy` = 0.
  - State IDLE; synchronizer registers = 0.
- **Latency:** a `line_in` change that meets setup before clock edge k is seen as `edge` after edge k+1. It is acted on at edge k+2.
  - `data_valid` goes high after clock edge k+2, where k is the clock edge at which the final data bit's mid-transition is first sampled.
  - `data_valid` lasts exactly one cycle.
- **`busy`:** rises one cycle after the start-bit `rise` is registered. Falls on entry to IDLE.
- **Tolerance:** the ±OVERSAMPLE/4 window and per-edge re-timing tolerate ±25% period jitter per bit.
- **Throughput:** back-to-back frames require at least OVERSAMPLE/2 idle-low clocks after the final bit boundary. A start `rise` arriving during GUARD is lost.

## Structure
- **Shared package `manchester_pkg`:**
  - state enum (`ST_IDLE`, `ST_DATA`, `ST_GUARD`);
  - line-code constants (`MC_ONE_RISE` = 1, `IDLE_LEVEL` = 0);
  - default `OVERSAMPLE`/`DATA_WIDTH`.
  - The encoder uses the same constants.
- **Sub-module `manchester_edge_sync`:** 2-FF synchronizer plus edge register. Outputs `edge`, `rise`, `fall`. Reset via `rst_n`.
- **Parent `manchester_decoder`:** FSM, counters, shift register, output registers.

## Test plan
All scenarios use `OVERSAMPLE=8`, ideal bit period 8 clocks.
- **Reset:** assert `rst_n`=0 for 3 cycles while `line_in` toggles -> all outputs 0, no `data_valid`/`frame_err`, `busy`=0.
- **Single byte:** send 0xA5 -> exactly one `data_valid` pulse with `data_out`=0xA5, at edge k+2 after the last mid-transition; `frame_err` stays 0.
- **Patterns back-to-back:** send 0x00 then 0xFF with an 8-clock idle gap between frames -> two pulses, `data_out` 0x00 then 0xFF; `busy` low in between.
- **Jitter:** send 0x3C with bit periods of 6 and 10 clocks alternating -> `data_out`=0x3C. Then 0x3C with one bit period of 11 clocks -> `frame_err` pulse, no `data_valid`, `data_out` holds 0x3C.
- **Truncated frame:** line goes low and stays low after 4 data bits -> `frame_err` exactly once at `cnt`=11, return to IDLE. A following 0x81 frame decodes correctly.
- **Enable/reset mid-frame:** drop `ena` for 1 cycle, or `rst_n` for 1 cycle, after 3 bits of 0x5A -> no strobes for that frame; busy=0 next cycle; next frame 0xC3 decodes to 0xC3.
